// File: rtl/clk_freq_meter.sv
`timescale 1ns/1ps
// clk_freq_meter: N-channel clock frequency meter.
// Each measured clock drives a free-running prescaler and a binary counter.
// The counter's registered Gray code crosses into clk_1 through a 2-flop
// synchroniser. A gate FSM snapshots every channel at the start and end of
// a GATE_CYCLES+1 cycle window and reports the differences.
// Optional feature: define CLK_FREQ_METER_RANGE_EN to add per-channel
// in_range flags (MIN_CNT <= count <= MAX_CNT).
module clk_freq_meter #(
    parameter int NCH         = 4,
    parameter int CW          = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int PRESC_LOG2  = 2,
    parameter int MIN_CNT     = 0,
    parameter int MAX_CNT     = 65535
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic [NCH-1:0]    meas_clk,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic              valid,
    output logic [NCH*CW-1:0] counts
`ifdef CLK_FREQ_METER_RANGE_EN
    ,
    output logic [NCH-1:0]    in_range
`endif
);

    localparam int GW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_DONE
    } state_t;

    function automatic logic [CW-1:0] bin2gray(input logic [CW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        b[CW-1] = g[CW-1];
        for (int k = CW - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic [CW-1:0] w_gray  [NCH];
    logic [CW-1:0] w_snap  [NCH];
    logic [CW-1:0] w_diff  [NCH];
    logic [CW-1:0] r_sync1 [NCH];
    logic [CW-1:0] r_sync2 [NCH];
    logic [CW-1:0] r_start [NCH];

    state_t              r_state;
    logic [GW-1:0]       r_gate_cnt;
    logic                r_busy;
    logic                r_valid;
    logic [NCH*CW-1:0]   r_counts;

    // Measured-domain counters: no reset, they simply start from their
    // power-up value of zero and free-run; only the differences matter.
    for (genvar i = 0; i < NCH; i++) begin : g_meas
        logic [CW-1:0] r_bin  = '0;
        logic [CW-1:0] r_gray = '0;

        if (PRESC_LOG2 > 0) begin : g_presc
            logic [PRESC_LOG2-1:0] r_presc = '0;

            // Prescale meas_clk, bump the binary count on prescaler wrap and
            // register its Gray encoding for the crossing.
            always_ff @(posedge meas_clk[i]) begin
                r_presc <= r_presc + 1'b1;
                if (&r_presc) begin
                    r_bin  <= r_bin + 1'b1;
                    r_gray <= bin2gray(r_bin + 1'b1);
                end
            end
        end else begin : g_nopresc
            // No prescaler: count every meas_clk edge.
            always_ff @(posedge meas_clk[i]) begin
                r_bin  <= r_bin + 1'b1;
                r_gray <= bin2gray(r_bin + 1'b1);
            end
        end

        assign w_gray[i] = r_gray;
        assign w_snap[i] = gray2bin(r_sync2[i]);
        assign w_diff[i] = w_snap[i] - r_start[i];
    end

    // Two-flop synchroniser per channel; only Gray values cross, so at most
    // one bit is in flight and the decoded snapshot is off by at most one.
    always_ff @(posedge clk_1) begin
        for (int k = 0; k < NCH; k++) begin
            if (!rst) begin
                r_sync1[k] <= '0;
                r_sync2[k] <= '0;
            end else begin
                r_sync1[k] <= w_gray[k];
                r_sync2[k] <= r_sync1[k];
            end
        end
    end

    // Gate FSM with registered busy/valid. The gate counter is loaded with
    // GATE_CYCLES and counts down to zero, so GATE spans GATE_CYCLES+1
    // cycles and the two snapshots are GATE_CYCLES+1 cycles apart. The end
    // snapshot feeds the subtraction directly so counts and valid appear
    // in the DONE cycle.
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_gate_cnt <= '0;
            r_counts   <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_start[k] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start || cont) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    for (int k = 0; k < NCH; k++) begin
                        r_start[k] <= w_snap[k];
                    end
                    r_gate_cnt <= GW'(GATE_CYCLES);
                    r_state    <= S_GATE;
                end
                S_GATE: begin
                    if (r_gate_cnt == '0) begin
                        for (int k = 0; k < NCH; k++) begin
                            r_counts[k*CW +: CW] <= w_diff[k];
                        end
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (cont) begin
                        r_state <= S_ARM;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign counts = r_counts;

`ifdef CLK_FREQ_METER_RANGE_EN
    logic [NCH-1:0] r_in_range;

    // Range flags follow the same update point as counts.
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            r_in_range <= '0;
        end else if (r_state == S_GATE && r_gate_cnt == '0) begin
            for (int k = 0; k < NCH; k++) begin
                r_in_range[k] <= (64'(w_diff[k]) >= 64'(MIN_CNT)) &&
                                 (64'(w_diff[k]) <= 64'(MAX_CNT));
            end
        end
    end

    assign in_range = r_in_range;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
`timescale 1ns/1ps
// Bench for clk_freq_meter: 20 MHz clk_1, 1000-cycle windows, four measured
// clocks at 20/15/10/5 MHz plus a CW=8 instance for wrap and stopped clock.
module tb_clk_freq_meter;

    localparam int CW  = 16;
    localparam int G   = 999;
    localparam int WIN = G + 3;

    logic          clk_1 = 1'b0;
    logic          rst;
    logic          start;
    logic          cont;
    logic [3:0]    mclk  = '0;
    logic [1:0]    mclk8 = '0;
    logic          busy, valid, busy8, valid8;
    logic [63:0]   counts;
    logic [15:0]   counts8;
`ifdef CLK_FREQ_METER_RANGE_EN
    logic [3:0]    in_range;
    logic [1:0]    in_range8;
`endif

    int n_total = 0;
    int n_bad   = 0;

    clk_freq_meter #(
        .NCH(4), .CW(CW), .GATE_CYCLES(G), .PRESC_LOG2(2),
        .MIN_CNT(120), .MAX_CNT(130)
    ) u_dut (
        .clk_1(clk_1), .rst(rst), .meas_clk(mclk), .start(start), .cont(cont),
        .busy(busy), .valid(valid), .counts(counts)
`ifdef CLK_FREQ_METER_RANGE_EN
        , .in_range(in_range)
`endif
    );

    clk_freq_meter #(
        .NCH(2), .CW(8), .GATE_CYCLES(G), .PRESC_LOG2(2),
        .MIN_CNT(1), .MAX_CNT(255)
    ) u_dut8 (
        .clk_1(clk_1), .rst(rst), .meas_clk(mclk8), .start(start), .cont(cont),
        .busy(busy8), .valid(valid8), .counts(counts8)
`ifdef CLK_FREQ_METER_RANGE_EN
        , .in_range(in_range8)
`endif
    );

    always #25 clk_1 = ~clk_1;
    initial begin #3.1;  forever #25     mclk[0]  = ~mclk[0];  end
    initial begin #11.7; forever #33.333 mclk[1]  = ~mclk[1];  end
    initial begin #7.9;  forever #50     mclk[2]  = ~mclk[2];  end
    initial begin #17.3; forever #100    mclk[3]  = ~mclk[3];  end
    initial begin #5.5;  forever #20.833 mclk8[0] = ~mclk8[0]; end

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        int d;
        d = got - exp;
        if (d < 0) d = -d;
        n_total++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    // Expected: 250, 187.5, 125, 62.5 (halves checked doubled), 300 mod 256, 0.
    task automatic check_counts(input string tag);
        chk({tag, "_c0"},   int'(counts[0*CW +: CW]), 250, 1);
        chk({tag, "_c1x2"}, 2 * int'(counts[1*CW +: CW]), 375, 2);
        chk({tag, "_c2"},   int'(counts[2*CW +: CW]), 125, 1);
        chk({tag, "_c3x2"}, 2 * int'(counts[3*CW +: CW]), 125, 2);
        chk({tag, "_w0"},   int'(counts8[7:0]), 44, 1);
        chk({tag, "_w1"},   int'(counts8[15:8]), 0);
        chk({tag, "_v8"},   int'(valid8), 1);
`ifdef CLK_FREQ_METER_RANGE_EN
        chk({tag, "_rng"},  int'(in_range), 4);
        chk({tag, "_rng8"}, int'(in_range8), 1);
`endif
    endtask

    task automatic watch(input int ncyc, input int poke_at, input int stop_after,
                         output int first_v, output int nv, output int first_idle);
        int prev_v;
        first_v = -1; nv = 0; first_idle = -1; prev_v = -1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk_1);
            start = (n == poke_at);
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = n;
                else chk("gap", n - prev_v, WIN);
                prev_v = n;
                check_counts("win");
                if (nv == stop_after) cont = 1'b0;
            end
            if (!busy && first_idle < 0) first_idle = n;
        end
    endtask

    initial begin
        int fv, nv, fi;
        rst = 1'b0; start = 1'b0; cont = 1'b0;
        repeat (3) @(negedge clk_1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_cnt_lo", int'(counts[31:0]), 0);
        chk("rst_cnt_hi", int'(counts[63:32]), 0);
        rst = 1'b1;
        repeat (20) @(negedge clk_1);

        // Single shot
        start = 1'b1;
        watch(WIN + 8, -1, 0, fv, nv, fi);
        chk("ss_first", fv, WIN);
        chk("ss_npulse", nv, 1);
        chk("ss_idle", fi, WIN + 1);

        // Continuous: three windows, then drop cont in the third DONE
        cont = 1'b1;
        watch(3 * WIN + 10, -1, 3, fv, nv, fi);
        chk("ct_first", fv, WIN);
        chk("ct_npulse", nv, 3);
        chk("ct_idle", fi, 3 * WIN + 1);

        // start pulsed mid-GATE is ignored
        start = 1'b1;
        watch(WIN + 8, 500, 0, fv, nv, fi);
        chk("ig_first", fv, WIN);
        chk("ig_npulse", nv, 1);
        chk("ig_idle", fi, WIN + 1);

        // Reset while the gate counter reads 500
        start = 1'b1;
        for (int n = 1; n <= 501; n++) begin
            @(negedge clk_1);
            start = 1'b0;
            if (n == 501) rst = 1'b0;
        end
        @(negedge clk_1);
        rst = 1'b1;
        chk("mr_busy",  int'(busy), 0);
        chk("mr_valid", int'(valid), 0);
        chk("mr_cnt_lo", int'(counts[31:0]), 0);
        chk("mr_cnt_hi", int'(counts[63:32]), 0);
        chk("mr_cnt8", int'(counts8), 0);
`ifdef CLK_FREQ_METER_RANGE_EN
        chk("mr_rng", int'(in_range), 0);
        chk("mr_rng8", int'(in_range8), 0);
`endif
        watch(600, -1, 0, fv, nv, fi);
        chk("mr_nopulse", nv, 0);

        // Fresh measurement after reset
        start = 1'b1;
        watch(WIN + 8, -1, 0, fv, nv, fi);
        chk("pr_first", fv, WIN);
        chk("pr_npulse", nv, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
